ssfr_cfg_sched: RTL
===================

Name: ssfr_cfg_sched

Overview:
- Per-layer configuration scheduler for the 16-bit SSFR control register of the NPU.
- Holds a small table of SSFR words, one per network layer.
- On START, writes each word into the SSFR through its DA/DB/EN_CONFIG write port, waits a settle time, launches the layer, then waits for that layer to finish.
- Also arbitrates direct host SSFR writes against the running sequence.

Parameters:
- NUM_LAYERS, 3, number of table entries and layers sequenced (1..2**LW).
- LW, 2, width of table address and layer index.
- SETTLE_CYC, 2, idle cycles between the EN_CONFIG pulse and LAYER_START (0..15).
- TIMEOUT, 1024, watchdog limit in cycles; used only with SSFR_SCHED_WDOG_EN.

Ports:
- CLKEXT  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- TBL_WE  in  1  table write strobe.
- TBL_ADDR  in  LW  table write address.
- TBL_DATA  in  16  table write data, {DA,DB} order.
- START  in  1  single-cycle pulse; begins a sequence.
- LAYER_DONE  in  1  single-cycle pulse from the datapath; current layer finished.
- HOST_REQ  in  1  host direct SSFR write request; level, held until granted.
- HOST_DA  in  8  host write, upper SSFR byte.
- HOST_DB  in  8  host write, lower SSFR byte.
- HOST_GNT  out  1  one-cycle pulse; host write issued this cycle.
- DA  out  8  SSFR upper byte to the register.
- DB  out  8  SSFR lower byte to the register.
- EN_CONFIG  out  1  SSFR load strobe.
- LAYER_START  out  1  one-cycle layer launch pulse.
- LAYER_IDX  out  LW  index of the layer being configured or run.
- BUSY  out  1  high whenever state is not IDLE.
- DONE  out  1  one-cycle pulse after the last layer completes.
- ERR  out  1  sticky error flag.

Behaviour:
- Reset: all outputs 0. State IDLE. Every table entry = 16'h2280, the SSFR power-on word. Watchdog counter = 0.
- All outputs are registered.
- Table writes:
  - Accepted only in IDLE; entry[TBL_ADDR] <= TBL_DATA.
  - TBL_ADDR >= NUM_LAYERS: ignored and sets ERR.
  - TBL_WE while BUSY: ignored and sets ERR.
- ERR is cleared by RST or by an accepted START.
- States: IDLE, CFG, SETTLE, KICK, WAIT, FIN.
- IDLE:
  - START=1 -> CFG with LAYER_IDX=0. START wins over a simultaneous HOST_REQ; the host stays pending.
  - Else HOST_REQ=1 -> for one cycle EN_CONFIG=1, {DA,DB}={HOST_DA,HOST_DB}, HOST_GNT=1; state stays IDLE. A held request is re-granted every cycle.
  - A START that arrives while BUSY is ignored and does not set ERR.
- CFG (exactly one cycle):
  - EN_CONFIG=1, {DA,DB}=entry[LAYER_IDX].
  - Next state SETTLE if SETTLE_CYC>0, else KICK.
- SETTLE: counts SETTLE_CYC cycles with EN_CONFIG=0, then KICK.
- KICK (one cycle): LAYER_START=1, then WAIT. LAYER_DONE is ignored in KICK.
- WAIT:
  - Holds until LAYER_DONE=1.
  - If LAYER_IDX==NUM_LAYERS-1 -> FIN; else LAYER_IDX+1 -> CFG.
- FIN (one cycle): DONE=1, then IDLE. LAYER_IDX resets to 0 on entering IDLE.
- HOST_REQ while BUSY: HOST_GNT stays 0. The host is serviced in the first IDLE cycle, i.e. the cycle after FIN.
- LAYER_DONE outside WAIT is ignored.
- Latency: START sampled at edge n gives EN_CONFIG high in cycle n+1 and LAYER_START high in cycle n+2+SETTLE_CYC.
- DA/DB hold their last value whenever EN_CONFIG=0.
- RST mid-sequence: immediate return to reset state. The table is also restored to 16'h2280.

Optional Feature:
- Macro: SSFR_SCHED_WDOG_EN.
- Defined:
  - A counter runs in WAIT and clears on each entry to WAIT.
  - Reaching TIMEOUT cycles without LAYER_DONE sets ERR and moves to FIN.
  - In that FIN, DONE stays 0, EN_CONFIG=1 and {DA,DB}=16'h2280, restoring the default SSFR word; then IDLE.
- Undefined: no counter; WAIT waits indefinitely; TIMEOUT is unused.

Test Plan:
- Reset, no stimulus -> all outputs 0, BUSY=0. After START with an unwritten table, first EN_CONFIG carries DA=8'h22, DB=8'h80.
- Write entries 0/1/2 = 16'h1111/16'h2222/16'h3333, SETTLE_CYC=2, START at cycle 0 -> EN_CONFIG at cycle 1 with 16'h1111, LAYER_START at cycle 4. LAYER_DONE at cycle 10 -> EN_CONFIG with 16'h2222 at cycle 11. After the third LAYER_DONE, DONE pulses once, then BUSY=0.
- HOST_REQ=1 with HOST_DA=8'hAB, HOST_DB=8'hCD, asserted the same cycle as START -> sequence runs and HOST_GNT stays 0 throughout. HOST_GNT and EN_CONFIG with 16'hABCD appear in the cycle after DONE.
- TBL_WE to address 1 with 16'hFFFF while BUSY -> entry unchanged, ERR=1. Next START clears ERR.
- RST asserted in SETTLE of layer 1 -> next cycle all outputs 0. Table reads back 16'h2280 on a subsequent run.
- With SSFR_SCHED_WDOG_EN and TIMEOUT=16, withhold LAYER_DONE -> 16 cycles into WAIT: ERR=1, EN_CONFIG with 16'h2280, DONE=0, return to IDLE.

Source files
------------

// File: rtl/ssfr_cfg_sched_if.sv
// Bus bundle for ssfr_cfg_sched: table load port, sequence control, host SSFR
// write path and the SSFR write port (DA/DB/EN_CONFIG) to the register.
interface ssfr_cfg_sched_if #(
    parameter int LW = 2
);
    logic          TBL_WE;
    logic [LW-1:0] TBL_ADDR;
    logic [15:0]   TBL_DATA;
    logic          START;
    logic          LAYER_DONE;
    logic          HOST_REQ;
    logic [7:0]    HOST_DA;
    logic [7:0]    HOST_DB;
    logic          HOST_GNT;
    logic [7:0]    DA;
    logic [7:0]    DB;
    logic          EN_CONFIG;
    logic          LAYER_START;
    logic [LW-1:0] LAYER_IDX;
    logic          BUSY;
    logic          DONE;
    logic          ERR;

    modport master (
        output TBL_WE, TBL_ADDR, TBL_DATA, START, LAYER_DONE,
               HOST_REQ, HOST_DA, HOST_DB,
        input  HOST_GNT, DA, DB, EN_CONFIG, LAYER_START, LAYER_IDX,
               BUSY, DONE, ERR
    );

    modport slave (
        input  TBL_WE, TBL_ADDR, TBL_DATA, START, LAYER_DONE,
               HOST_REQ, HOST_DA, HOST_DB,
        output HOST_GNT, DA, DB, EN_CONFIG, LAYER_START, LAYER_IDX,
               BUSY, DONE, ERR
    );
endinterface

// File: rtl/ssfr_cfg_sched.sv
// Per-layer SSFR configuration scheduler with host write arbitration.
// Optional WAIT watchdog enabled by defining SSFR_SCHED_WDOG_EN.
module ssfr_cfg_sched #(
    parameter int NUM_LAYERS = 3,
    parameter int LW         = 2,
    parameter int SETTLE_CYC = 2,
    parameter int TIMEOUT    = 1024
) (
    input logic              CLKEXT,
    input logic              RST,
    ssfr_cfg_sched_if.slave  bus
);
    localparam logic [15:0]   SSFR_POR  = 16'h2280;
    localparam logic [LW:0]   NL_W      = (LW+1)'(NUM_LAYERS);
    localparam logic [LW-1:0] LAST_IDX  = LW'(NUM_LAYERS - 1);
    localparam logic [3:0]    SET_LAST  = 4'((SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_SETTLE, S_KICK, S_WAIT, S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [15:0]   tbl_q [NUM_LAYERS];
    logic          tbl_wr;
    logic          addr_ok;

    logic          gnt_q, gnt_d;
    logic          en_q, en_d;
    logic          ls_q, ls_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [7:0]    da_q, db_q;
    logic [15:0]   ssfr_d;

`ifdef SSFR_SCHED_WDOG_EN
    localparam int             WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    logic [WDW-1:0] wd_q, wd_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    assign addr_ok = ({1'b0, bus.TBL_ADDR} < NL_W);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        gnt_d   = 1'b0;
        en_d    = 1'b0;
        ls_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        ssfr_d  = {da_q, db_q};
        tbl_wr  = 1'b0;
`ifdef SSFR_SCHED_WDOG_EN
        wd_d    = wd_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                // START outranks the host; a pending host request waits for the next IDLE cycle
                if (bus.START) begin
                    state_d = S_CFG;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end else if (bus.HOST_REQ) begin
                    gnt_d  = 1'b1;
                    en_d   = 1'b1;
                    ssfr_d = {bus.HOST_DA, bus.HOST_DB};
                end
            end
            S_CFG: begin
                cnt_d   = '0;
                state_d = (SETTLE_CYC > 0) ? S_SETTLE : S_KICK;
            end
            S_SETTLE: begin
                if (cnt_q == SET_LAST) state_d = S_KICK;
                else                   cnt_d   = cnt_q + 4'd1;
            end
            S_KICK: begin
                state_d = S_WAIT;
`ifdef SSFR_SCHED_WDOG_EN
                wd_d    = '0;
`endif
            end
            S_WAIT: begin
                if (bus.LAYER_DONE) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_CFG;
                        idx_d   = idx_q + 1'b1;
                    end
                end
`ifdef SSFR_SCHED_WDOG_EN
                else if (wd_q == WD_LAST) begin
                    // Stalled layer: abort and put the SSFR back to its power-on word
                    state_d = S_FIN;
                    err_d   = 1'b1;
                    en_d    = 1'b1;
                    ssfr_d  = SSFR_POR;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            S_FIN: begin
                state_d = S_IDLE;
                idx_d   = '0;
                if (bus.HOST_REQ) begin
                    gnt_d  = 1'b1;
                    en_d   = 1'b1;
                    ssfr_d = {bus.HOST_DA, bus.HOST_DB};
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_CFG) begin
            en_d   = 1'b1;
            ssfr_d = tbl_q[idx_d];
        end
        ls_d   = (state_d == S_KICK);
        busy_d = (state_d != S_IDLE);

        if (bus.TBL_WE) begin
            if (state_q == S_IDLE && addr_ok) tbl_wr = 1'b1;
            else                              err_d  = 1'b1;
        end
    end

    always_ff @(posedge CLKEXT) begin
        if (RST) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= 1'b0;
            en_q    <= 1'b0;
            ls_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            da_q    <= '0;
            db_q    <= '0;
            for (int i = 0; i < NUM_LAYERS; i++) tbl_q[i] <= SSFR_POR;
`ifdef SSFR_SCHED_WDOG_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            en_q    <= en_d;
            ls_q    <= ls_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            da_q    <= ssfr_d[15:8];
            db_q    <= ssfr_d[7:0];
            if (tbl_wr) tbl_q[bus.TBL_ADDR] <= bus.TBL_DATA;
`ifdef SSFR_SCHED_WDOG_EN
            wd_q    <= wd_d;
`endif
        end
    end

    assign bus.HOST_GNT    = gnt_q;
    assign bus.EN_CONFIG   = en_q;
    assign bus.LAYER_START = ls_q;
    assign bus.LAYER_IDX   = idx_q;
    assign bus.BUSY        = busy_q;
    assign bus.DONE        = done_q;
    assign bus.ERR         = err_q;
    assign bus.DA          = da_q;
    assign bus.DB          = db_q;
endmodule
